// File: rtl/rs_unified_param.sv
// rtl/rs_unified_param.sv - parametrised unified reservation station with tag wakeup and oldest-first issue
module rs_unified_param #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int NUM_ALU    = 2,
  parameter int NUM_WB     = 2,
  parameter int PREG_W     = 6,
  parameter int DATA_W     = 32,
  parameter int SEQ_W      = 5,
  localparam int NUM_FU    = NUM_ALU + 1,
  localparam int CNT_W     = $clog2(DEPTH) + 1,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int FU_W      = $clog2(NUM_FU)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [DISPATCH_W-1:0]        disp_valid,
  output logic                         disp_ready,
  input  logic [DISPATCH_W*7-1:0]      disp_opcode,
  input  logic [DISPATCH_W*3-1:0]      disp_alu_op,
  input  logic [DISPATCH_W*PREG_W-1:0] disp_rd,
  input  logic [DISPATCH_W*PREG_W-1:0] disp_rs1,
  input  logic [DISPATCH_W*PREG_W-1:0] disp_rs2,
  input  logic [DISPATCH_W*DATA_W-1:0] disp_rs1_val,
  input  logic [DISPATCH_W*DATA_W-1:0] disp_rs2_val,
  input  logic [DISPATCH_W-1:0]        disp_rs1_rdy,
  input  logic [DISPATCH_W-1:0]        disp_rs2_rdy,
  input  logic [DISPATCH_W*DATA_W-1:0] disp_imm,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]     wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]     wb_data,
  output logic [NUM_FU-1:0]            iss_valid,
  input  logic [NUM_FU-1:0]            iss_ready,
  output logic [NUM_FU*7-1:0]          iss_opcode,
  output logic [NUM_FU*3-1:0]          iss_alu_op,
  output logic [NUM_FU*PREG_W-1:0]     iss_rd,
  output logic [NUM_FU*DATA_W-1:0]     iss_src1,
  output logic [NUM_FU*DATA_W-1:0]     iss_src2,
  output logic [NUM_FU*DATA_W-1:0]     iss_imm,
  output logic [NUM_FU*SEQ_W-1:0]      iss_seq,
  output logic [CNT_W-1:0]             count,
  output logic                         err_opcode
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  typedef struct packed {
    logic              valid;
    logic [6:0]        opcode;
    logic [2:0]        alu_op;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] tag1;
    logic [PREG_W-1:0] tag2;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] imm;
    logic              rdy1;
    logic              rdy2;
    logic [SEQ_W-1:0]  seq;
    logic [FU_W-1:0]   fu;
  } entry_t;

  entry_t            ent   [DEPTH];
  entry_t            ent_n [DEPTH];
  logic [SEQ_W-1:0]  seq_q, seq_n;
  logic [FU_W-1:0]   rr_q, rr_n;
  logic [CNT_W-1:0]  count_n, n_alloc, n_free;
  logic              err_n;

  logic [NUM_FU-1:0] iss_v;
  logic [6:0]        iss_op_q  [NUM_FU];
  logic [2:0]        iss_alu_q [NUM_FU];
  logic [PREG_W-1:0] iss_rd_q  [NUM_FU];
  logic [DATA_W-1:0] iss_s1_q  [NUM_FU];
  logic [DATA_W-1:0] iss_s2_q  [NUM_FU];
  logic [DATA_W-1:0] iss_imm_q [NUM_FU];
  logic [SEQ_W-1:0]  iss_seq_q [NUM_FU];

  logic [NUM_FU-1:0] sel_found, take;
  logic [IDX_W-1:0]  sel_idx [NUM_FU];
  logic [SEQ_W-1:0]  sel_age [NUM_FU];
  logic [SEQ_W-1:0]  age;

  logic [DEPTH-1:0]  taken;
  logic              placed, d_alu, d_mem, d_rdy1, d_rdy2;
  logic [6:0]        d_op;
  logic [DATA_W-1:0] d_val1, d_val2;

  assign disp_ready = (count <= CNT_W'(DEPTH - DISPATCH_W));

  // Oldest ready entry per unit, judged by distance from the running sequence counter
  always_comb begin
    sel_found = '0;
    take      = '0;
    age       = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sel_idx[f] = '0;
      sel_age[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        age = seq_q - ent[i].seq;
        if (ent[i].valid && ent[i].rdy1 && ent[i].rdy2 && ent[i].fu == FU_W'(f) &&
            (!sel_found[f] || age > sel_age[f])) begin
          sel_found[f] = 1'b1;
          sel_idx[f]   = IDX_W'(i);
          sel_age[f]   = age;
        end
      end
      take[f] = sel_found[f] && (!iss_v[f] || iss_ready[f]);
    end
  end

  // Next entry state: wakeup, release of issued entries, then in-order allocation of the dispatch group
  always_comb begin
    ent_n   = ent;
    seq_n   = seq_q;
    rr_n    = rr_q;
    err_n   = 1'b0;
    taken   = '0;
    placed  = 1'b0;
    n_alloc = '0;
    n_free  = '0;
    d_op    = '0;
    d_alu   = 1'b0;
    d_mem   = 1'b0;
    d_val1  = '0;
    d_val2  = '0;
    d_rdy1  = 1'b0;
    d_rdy2  = 1'b0;
    // ports scanned high to low so the lowest matching port is the one that sticks
    for (int i = 0; i < DEPTH; i++) begin
      for (int w = NUM_WB - 1; w >= 0; w--) begin
        if (ent[i].valid && wb_valid[w]) begin
          if (!ent[i].rdy1 && ent[i].tag1 == wb_tag[w*PREG_W +: PREG_W]) begin
            ent_n[i].src1 = wb_data[w*DATA_W +: DATA_W];
            ent_n[i].rdy1 = 1'b1;
          end
          if (!ent[i].rdy2 && ent[i].tag2 == wb_tag[w*PREG_W +: PREG_W]) begin
            ent_n[i].src2 = wb_data[w*DATA_W +: DATA_W];
            ent_n[i].rdy2 = 1'b1;
          end
        end
      end
    end
    for (int f = 0; f < NUM_FU; f++) begin
      if (take[f]) begin
        ent_n[sel_idx[f]].valid = 1'b0;
        n_free = n_free + CNT_W'(1);
      end
    end
    if (disp_ready) begin
      for (int s = 0; s < DISPATCH_W; s++) begin
        d_op   = disp_opcode[s*7 +: 7];
        d_alu  = (d_op == OP_R) || (d_op == OP_I);
        d_mem  = (d_op == OP_LD) || (d_op == OP_ST);
        d_val1 = disp_rs1_val[s*DATA_W +: DATA_W];
        d_val2 = disp_rs2_val[s*DATA_W +: DATA_W];
        d_rdy1 = disp_rs1_rdy[s];
        d_rdy2 = disp_rs2_rdy[s];
        for (int w = NUM_WB - 1; w >= 0; w--) begin
          if (wb_valid[w] && !disp_rs1_rdy[s] &&
              disp_rs1[s*PREG_W +: PREG_W] == wb_tag[w*PREG_W +: PREG_W]) begin
            d_val1 = wb_data[w*DATA_W +: DATA_W];
            d_rdy1 = 1'b1;
          end
          if (wb_valid[w] && !disp_rs2_rdy[s] &&
              disp_rs2[s*PREG_W +: PREG_W] == wb_tag[w*PREG_W +: PREG_W]) begin
            d_val2 = wb_data[w*DATA_W +: DATA_W];
            d_rdy2 = 1'b1;
          end
        end
        if (d_op == OP_I || d_op == OP_LD) d_rdy2 = 1'b1;
        if (disp_valid[s] && !(d_alu || d_mem)) err_n = 1'b1;
        if (disp_valid[s] && (d_alu || d_mem)) begin
          placed = 1'b0;
          for (int i = 0; i < DEPTH; i++) begin
            if (!placed && !ent[i].valid && !taken[i]) begin
              placed          = 1'b1;
              taken[i]        = 1'b1;
              ent_n[i].valid  = 1'b1;
              ent_n[i].opcode = d_op;
              ent_n[i].alu_op = disp_alu_op[s*3 +: 3];
              ent_n[i].rd     = disp_rd[s*PREG_W +: PREG_W];
              ent_n[i].tag1   = disp_rs1[s*PREG_W +: PREG_W];
              ent_n[i].tag2   = disp_rs2[s*PREG_W +: PREG_W];
              ent_n[i].src1   = d_val1;
              ent_n[i].src2   = d_val2;
              ent_n[i].imm    = disp_imm[s*DATA_W +: DATA_W];
              ent_n[i].rdy1   = d_rdy1;
              ent_n[i].rdy2   = d_rdy2;
              ent_n[i].seq    = seq_n;
              ent_n[i].fu     = d_mem ? FU_W'(NUM_ALU) : rr_n;
            end
          end
          seq_n   = seq_n + SEQ_W'(1);
          n_alloc = n_alloc + CNT_W'(1);
          if (d_alu) rr_n = (rr_n == FU_W'(NUM_ALU - 1)) ? '0 : rr_n + FU_W'(1);
        end
      end
    end
    count_n = count + n_alloc - n_free;
  end

  // State registers; flush clears like reset but keeps sequence and round-robin position
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      for (int f = 0; f < NUM_FU; f++) begin
        iss_op_q[f]  <= '0;
        iss_alu_q[f] <= '0;
        iss_rd_q[f]  <= '0;
        iss_s1_q[f]  <= '0;
        iss_s2_q[f]  <= '0;
        iss_imm_q[f] <= '0;
        iss_seq_q[f] <= '0;
      end
      iss_v      <= '0;
      count      <= '0;
      err_opcode <= 1'b0;
      if (!rst_n) begin
        seq_q <= '0;
        rr_q  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
      seq_q      <= seq_n;
      rr_q       <= rr_n;
      count      <= count_n;
      err_opcode <= err_n;
      for (int f = 0; f < NUM_FU; f++) begin
        if (!iss_v[f] || iss_ready[f]) begin
          iss_v[f] <= sel_found[f];
          if (sel_found[f]) begin
            iss_op_q[f]  <= ent[sel_idx[f]].opcode;
            iss_alu_q[f] <= ent[sel_idx[f]].alu_op;
            iss_rd_q[f]  <= ent[sel_idx[f]].rd;
            iss_s1_q[f]  <= ent[sel_idx[f]].src1;
            iss_s2_q[f]  <= ent[sel_idx[f]].src2;
            iss_imm_q[f] <= ent[sel_idx[f]].imm;
            iss_seq_q[f] <= ent[sel_idx[f]].seq;
          end
        end
      end
    end
  end

  assign iss_valid = iss_v;

  // Flatten issue registers onto the per-unit output buses
  for (genvar f = 0; f < NUM_FU; f++) begin : g_iss_out
    assign iss_opcode[f*7 +: 7]        = iss_op_q[f];
    assign iss_alu_op[f*3 +: 3]        = iss_alu_q[f];
    assign iss_rd[f*PREG_W +: PREG_W]  = iss_rd_q[f];
    assign iss_src1[f*DATA_W +: DATA_W] = iss_s1_q[f];
    assign iss_src2[f*DATA_W +: DATA_W] = iss_s2_q[f];
    assign iss_imm[f*DATA_W +: DATA_W]  = iss_imm_q[f];
    assign iss_seq[f*SEQ_W +: SEQ_W]    = iss_seq_q[f];
  end

endmodule
